// File: rtl/mem_arb_pkg.sv
// Shared types for the memory port scheduler: FSM states, request owners and
// the saturating starvation counter helper.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_WAIT = 2'd2,
    ST_RESP = 2'd3
  } state_e;

  typedef enum logic [1:0] {
    OWN_IF = 2'd0,
    OWN_DR = 2'd1,
    OWN_DW = 2'd2
  } owner_e;

  localparam int unsigned STARVE_W = 4;

  function automatic logic [STARVE_W-1:0] sat_inc(input logic [STARVE_W-1:0] val,
                                                  input logic [STARVE_W-1:0] lim);
    return (val >= lim) ? lim : val + 4'd1;
  endfunction

endpackage

// File: rtl/mem_port_prio_pick.sv
// Priority picker for the shared memory port: write > read > fetch, with a
// starvation counter that forces fetch through after STARVE_LIMIT data accepts.
module mem_port_prio_pick
  import mem_arb_pkg::*;
#(
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                pick_en,
  input  logic                if_valid,
  input  logic                dr_valid,
  input  logic                dw_valid,
  output logic                if_ready,
  output logic                dr_ready,
  output logic                dw_ready,
  output logic                accept,
  output owner_e              accept_owner,
  output logic [STARVE_W-1:0] starve_cnt
);

  localparam logic [STARVE_W-1:0] LIMIT_C = STARVE_W'(STARVE_LIMIT);

  logic [STARVE_W-1:0] starve_cnt_r;
  logic                fetch_forced_s;

  assign fetch_forced_s = if_valid && (starve_cnt_r == LIMIT_C);
  assign starve_cnt     = starve_cnt_r;

  // Select one requester and raise only its ready while the port is idle.
  always_comb begin
    if_ready     = 1'b0;
    dr_ready     = 1'b0;
    dw_ready     = 1'b0;
    accept_owner = OWN_IF;
    if (pick_en) begin
      if (fetch_forced_s) begin
        if_ready     = 1'b1;
        accept_owner = OWN_IF;
      end else if (dw_valid) begin
        dw_ready     = 1'b1;
        accept_owner = OWN_DW;
      end else if (dr_valid) begin
        dr_ready     = 1'b1;
        accept_owner = OWN_DR;
      end else if (if_valid) begin
        if_ready     = 1'b1;
        accept_owner = OWN_IF;
      end else begin
        accept_owner = OWN_IF;
      end
    end else begin
      accept_owner = OWN_IF;
    end
  end

  // Ready is only raised toward a valid requester, so any ready is an accept.
  assign accept = if_ready | dr_ready | dw_ready;

  // Count data-side accepts that overtake a waiting fetch.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      starve_cnt_r <= 4'd0;
    end else if (pick_en) begin
      if (!if_valid) begin
        starve_cnt_r <= 4'd0;
      end else if (accept && (accept_owner == OWN_IF)) begin
        starve_cnt_r <= 4'd0;
      end else if (accept) begin
        starve_cnt_r <= sat_inc(starve_cnt_r, LIMIT_C);
      end
    end
  end

endmodule

// File: rtl/mem_port_scheduler.sv
// Shares the single memory port between fetch, data-read and data-write:
// one transaction in flight, registered memory request and one-cycle responses.
module mem_port_scheduler
  import mem_arb_pkg::*;
#(
  parameter int unsigned XLEN         = 32,
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              if_valid,
  output logic              if_ready,
  input  logic [XLEN-1:0]   if_addr,
  output logic [XLEN-1:0]   if_rdata,
  output logic              if_resp,
  input  logic              dw_valid,
  output logic              dw_ready,
  input  logic [XLEN-1:0]   dw_addr,
  input  logic [XLEN-1:0]   dw_wdata,
  input  logic [XLEN/8-1:0] dw_strb,
  output logic              dw_resp,
  input  logic              dr_valid,
  output logic              dr_ready,
  input  logic [XLEN-1:0]   dr_addr,
  output logic [XLEN-1:0]   dr_rdata,
  output logic              dr_resp,
  output logic              mem_req,
  output logic              mem_we,
  output logic [XLEN-1:0]   mem_addr,
  output logic [XLEN-1:0]   mem_wdata,
  output logic [XLEN/8-1:0] mem_wstrb,
  input  logic              mem_gnt,
  input  logic              mem_rvalid,
  input  logic [XLEN-1:0]   mem_rdata
);

  state_e              state_r;
  owner_e              owner_r;
  logic                accept_s;
  owner_e              accept_owner_s;
  logic [STARVE_W-1:0] starve_cnt_s;

  mem_port_prio_pick #(
    .STARVE_LIMIT(STARVE_LIMIT)
  ) u_pick (
    .clk         (clk),
    .rst_n       (rst_n),
    .pick_en     (state_r == ST_IDLE),
    .if_valid    (if_valid),
    .dr_valid    (dr_valid),
    .dw_valid    (dw_valid),
    .if_ready    (if_ready),
    .dr_ready    (dr_ready),
    .dw_ready    (dw_ready),
    .accept      (accept_s),
    .accept_owner(accept_owner_s),
    .starve_cnt  (starve_cnt_s)
  );

  // Transaction FSM; the memory request fields double as the capture registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r   <= ST_IDLE;
      owner_r   <= OWN_IF;
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      mem_wstrb <= '0;
      if_resp   <= 1'b0;
      dr_resp   <= 1'b0;
      dw_resp   <= 1'b0;
      if_rdata  <= '0;
      dr_rdata  <= '0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (accept_s) begin
            owner_r <= accept_owner_s;
            mem_req <= 1'b1;
            state_r <= ST_REQ;
            case (accept_owner_s)
              OWN_DW: begin
                mem_we    <= 1'b1;
                mem_addr  <= dw_addr;
                mem_wdata <= dw_wdata;
                mem_wstrb <= dw_strb;
              end
              OWN_DR: begin
                mem_we    <= 1'b0;
                mem_addr  <= dr_addr;
                mem_wdata <= '0;
                mem_wstrb <= '0;
              end
              default: begin
                mem_we    <= 1'b0;
                mem_addr  <= if_addr;
                mem_wdata <= '0;
                mem_wstrb <= '0;
              end
            endcase
          end
        end
        ST_REQ: begin
          if (mem_gnt) begin
            mem_req <= 1'b0;
            state_r <= ST_WAIT;
          end
        end
        ST_WAIT: begin
          if (mem_rvalid) begin
            state_r <= ST_RESP;
            case (owner_r)
              OWN_DW: dw_resp <= 1'b1;
              OWN_DR: begin
                dr_resp  <= 1'b1;
                dr_rdata <= mem_rdata;
              end
              default: begin
                if_resp  <= 1'b1;
                if_rdata <= mem_rdata;
              end
            endcase
          end
        end
        ST_RESP: begin
          if_resp  <= 1'b0;
          dr_resp  <= 1'b0;
          dw_resp  <= 1'b0;
          if_rdata <= '0;
          dr_rdata <= '0;
          state_r  <= ST_IDLE;
        end
        default: begin
          mem_req <= 1'b0;
          state_r <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_port_scheduler.sv
// Directed bench for mem_port_scheduler: priority, latency, held requests,
// starvation guard, payload isolation and mid-transaction reset.
module tb_mem_port_scheduler;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        if_valid, if_ready, if_resp;
  logic [31:0] if_addr, if_rdata;
  logic        dw_valid, dw_ready, dw_resp;
  logic [31:0] dw_addr, dw_wdata;
  logic [3:0]  dw_strb;
  logic        dr_valid, dr_ready, dr_resp;
  logic [31:0] dr_addr, dr_rdata;
  logic        mem_req, mem_we, mem_gnt, mem_rvalid;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic [3:0]  mem_wstrb;

  int pass_cnt = 0;
  int total_cnt = 0;

  always #5 clk = ~clk;

  mem_port_scheduler #(.XLEN(32), .STARVE_LIMIT(4)) u_dut (
    .clk(clk), .rst_n(rst_n),
    .if_valid(if_valid), .if_ready(if_ready), .if_addr(if_addr),
    .if_rdata(if_rdata), .if_resp(if_resp),
    .dw_valid(dw_valid), .dw_ready(dw_ready), .dw_addr(dw_addr),
    .dw_wdata(dw_wdata), .dw_strb(dw_strb), .dw_resp(dw_resp),
    .dr_valid(dr_valid), .dr_ready(dr_ready), .dr_addr(dr_addr),
    .dr_rdata(dr_rdata), .dr_resp(dr_resp),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb), .mem_gnt(mem_gnt),
    .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total_cnt++;
    if (got === exp) pass_cnt++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
  endtask

  // Advance one cycle; inputs are then driven 2ns after the rising edge.
  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic check_idle_outputs(input string tag);
    check_eq({tag, "_req"}, {31'd0, mem_req}, 32'd0);
    check_eq({tag, "_resp"}, {29'd0, if_resp, dr_resp, dw_resp}, 32'd0);
    check_eq({tag, "_rdata"}, if_rdata | dr_rdata, 32'd0);
  endtask

  initial begin
    rst_n = 1'b0;
    if_valid = 1'b0; if_addr = 32'h0;
    dw_valid = 1'b0; dw_addr = 32'h0; dw_wdata = 32'h0; dw_strb = 4'h0;
    dr_valid = 1'b0; dr_addr = 32'h0;
    mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = 32'h0;
    tick();
    tick();
    check_idle_outputs("reset");
    check_eq("reset_addr", mem_addr, 32'h0);
    check_eq("reset_we", {31'd0, mem_we}, 32'd0);
    rst_n = 1'b1;
    tick();

    // Write wins over read and fetch, minimum latency.
    dw_valid = 1'b1; dw_addr = 32'h100; dw_wdata = 32'hDEADBEEF; dw_strb = 4'hF;
    dr_valid = 1'b1; dr_addr = 32'h200;
    if_valid = 1'b1; if_addr = 32'h40;
    #1;
    check_eq("prio_ready", {29'd0, dw_ready, dr_ready, if_ready}, 32'h4);
    tick();
    dw_valid = 1'b0; dr_valid = 1'b0; if_valid = 1'b0;
    check_eq("wr_req", {31'd0, mem_req}, 32'd1);
    check_eq("wr_we", {31'd0, mem_we}, 32'd1);
    check_eq("wr_addr", mem_addr, 32'h100);
    check_eq("wr_wdata", mem_wdata, 32'hDEADBEEF);
    check_eq("wr_strb", {28'd0, mem_wstrb}, 32'hF);
    check_eq("wr_busy_ready", {29'd0, dw_ready, dr_ready, if_ready}, 32'h0);
    mem_gnt = 1'b1;
    tick();
    mem_gnt = 1'b0;
    check_eq("wr_req_drop", {31'd0, mem_req}, 32'd0);
    mem_rvalid = 1'b1;
    tick();
    mem_rvalid = 1'b0;
    check_eq("wr_resp", {29'd0, if_resp, dr_resp, dw_resp}, 32'h1);
    tick();
    check_eq("wr_resp_end", {31'd0, dw_resp}, 32'd0);

    // Read with delayed grant; payload change after accept must not leak.
    dr_valid = 1'b1; dr_addr = 32'h200;
    #1;
    check_eq("rd_ready", {29'd0, dw_ready, dr_ready, if_ready}, 32'h2);
    tick();
    dr_valid = 1'b0; dr_addr = 32'h300;
    for (int k = 0; k < 4; k++) begin
      check_eq($sformatf("rd_hold_req%0d", k), {31'd0, mem_req}, 32'd1);
      check_eq($sformatf("rd_hold_addr%0d", k), mem_addr, 32'h200);
      check_eq($sformatf("rd_hold_we%0d", k), {27'd0, mem_we, mem_wstrb}, 32'h0);
      if (k == 3) mem_gnt = 1'b1;
      tick();
    end
    mem_gnt = 1'b0;
    check_eq("rd_req_drop", {31'd0, mem_req}, 32'd0);
    mem_rdata = 32'hFFFFFFFF;
    tick();
    mem_rvalid = 1'b1; mem_rdata = 32'h12345678;
    tick();
    mem_rvalid = 1'b0; mem_rdata = 32'h0;
    check_eq("rd_resp", {29'd0, if_resp, dr_resp, dw_resp}, 32'h2);
    check_eq("rd_rdata", dr_rdata, 32'h12345678);
    check_eq("rd_if_rdata", if_rdata, 32'h0);
    tick();
    check_eq("rd_resp_end", {31'd0, dr_resp}, 32'd0);
    check_eq("rd_rdata_end", dr_rdata, 32'h0);

    // Starvation guard: four reads overtake fetch, the fifth accept is fetch.
    if_valid = 1'b1; if_addr = 32'h40;
    dr_valid = 1'b1; dr_addr = 32'h500;
    for (int i = 0; i < 5; i++) begin
      #1;
      if (i < 4) check_eq($sformatf("starve_ready%0d", i), {29'd0, dw_ready, dr_ready, if_ready}, 32'h2);
      else       check_eq($sformatf("starve_ready%0d", i), {29'd0, dw_ready, dr_ready, if_ready}, 32'h1);
      tick();
      check_eq($sformatf("starve_addr%0d", i), mem_addr, (i < 4) ? 32'h500 : 32'h40);
      mem_gnt = 1'b1;
      tick();
      mem_gnt = 1'b0; mem_rvalid = 1'b1; mem_rdata = 32'hA0 + 32'(i);
      tick();
      mem_rvalid = 1'b0;
      if (i < 4) begin
        check_eq($sformatf("starve_resp%0d", i), {29'd0, if_resp, dr_resp, dw_resp}, 32'h2);
        check_eq($sformatf("starve_rdata%0d", i), dr_rdata, 32'hA0 + 32'(i));
      end else begin
        check_eq($sformatf("starve_resp%0d", i), {29'd0, if_resp, dr_resp, dw_resp}, 32'h4);
        check_eq($sformatf("starve_rdata%0d", i), if_rdata, 32'hA4);
      end
      tick();
    end
    check_eq("starve_cnt_clear", {28'd0, u_dut.u_pick.starve_cnt_r}, 32'd0);
    if_valid = 1'b0; dr_valid = 1'b0;
    tick();

    // Reset while waiting for the response aborts the fetch.
    if_valid = 1'b1; if_addr = 32'h80;
    tick();
    if_valid = 1'b0; mem_gnt = 1'b1;
    tick();
    mem_gnt = 1'b0;
    rst_n = 1'b0;
    #1;
    check_idle_outputs("midrst");
    check_eq("midrst_addr", mem_addr, 32'h0);
    tick();
    rst_n = 1'b1;
    mem_rvalid = 1'b1; mem_rdata = 32'h55AA55AA;
    tick();
    mem_rvalid = 1'b0;
    check_idle_outputs("stray1");
    tick();
    check_idle_outputs("stray2");

    // Normal fetch after the aborted one.
    if_valid = 1'b1; if_addr = 32'h84;
    #1;
    check_eq("fetch_ready", {29'd0, dw_ready, dr_ready, if_ready}, 32'h1);
    tick();
    if_valid = 1'b0;
    check_eq("fetch_addr", mem_addr, 32'h84);
    mem_gnt = 1'b1;
    tick();
    mem_gnt = 1'b0; mem_rvalid = 1'b1; mem_rdata = 32'hCAFEF00D;
    tick();
    mem_rvalid = 1'b0;
    check_eq("fetch_resp", {29'd0, if_resp, dr_resp, dw_resp}, 32'h4);
    check_eq("fetch_rdata", if_rdata, 32'hCAFEF00D);
    tick();
    check_idle_outputs("fetch_end");

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/mem_port_scheduler.md
# mem_port_scheduler

Sequential scheduler that shares the core's single memory port between the instruction-fetch, data-read and data-write requesters. It accepts one request at a time, holds it on the memory port until the memory grants it, waits for the memory response, and returns a one-cycle response to the owning requester. Writes have the highest priority and reads the next, with a starvation guard so instruction fetch cannot be locked out. It sits between the core's fetch/LSU native interfaces and the memory (or bus bridge).

## Interface
- XLEN, 32, data/address width
- STARVE_LIMIT, 4, consecutive data-side accepts allowed while fetch is waiting before fetch is forced first (1..15)
- clk  in  1  clock, rising edge
- rst_n  in  1  reset, asynchronous, active-low
- if_valid / if_ready  in / out  1  fetch request handshake
- if_addr  in  XLEN  fetch address
- if_rdata  out  XLEN  fetched instruction, valid with if_resp
- if_resp  out  1  one-cycle fetch completion
- dw_valid / dw_ready  in / out  1  write request handshake
- dw_addr, dw_wdata  in  XLEN  write address / data
- dw_strb  in  XLEN/8  byte enables
- dw_resp  out  1  one-cycle write completion
- dr_valid / dr_ready  in / out  1  read request handshake
- dr_addr  in  XLEN  read address
- dr_rdata  out  XLEN  read data, valid with dr_resp
- dr_resp  out  1  one-cycle read completion
- mem_req  out  1  memory request, held until mem_gnt
- mem_we  out  1  1 = write
- mem_addr, mem_wdata  out  XLEN  registered request fields
- mem_wstrb  out  XLEN/8  byte enables (all zero for reads)
- mem_gnt  in  1  memory accepted request this cycle
- mem_rvalid  in  1  response / write ack
- mem_rdata  in  XLEN  read data, valid with mem_rvalid

## Operation
- FSM: IDLE -> REQ -> WAIT -> RESP -> IDLE. Exactly one transaction in flight.
- IDLE: the picker selects one valid requester and raises only its ready (combinational from the valid inputs). valid&&ready captures owner, addr, wdata and strb into registers and moves to REQ. No valid: stay in IDLE, all readies 0.
- Priority: dw > dr > if. Exception: if starve_cnt == STARVE_LIMIT and if_valid, fetch wins.
- starve_cnt: +1 on every dw/dr accept while if_valid=1 (saturating); cleared on a fetch accept or when if_valid=0 in IDLE.
- REQ: mem_req=1 with the registered fields; on mem_gnt go to WAIT. mem_rvalid in REQ is ignored.
- WAIT: on mem_rvalid capture mem_rdata (reads/fetch only) and go to RESP.
- RESP: assert the owner's resp for exactly one cycle; if_rdata/dr_rdata = captured data while that resp is high, otherwise 0. Return to IDLE.
- Requesters hold valid and payload until ready. Payload changes after acceptance have no effect. Dropping valid before ready is legal.
- mem_rvalid while in IDLE is discarded.

## Timing
- Reset (async assert, sync release): state=IDLE, starve_cnt=0, all outputs 0, captured registers 0.
- Minimum latency: accept at cycle 0, mem_req at cycle 1 (mem_gnt is also 1 in that cycle), mem_rvalid at cycle 2, resp at cycle 3.
- A new accept is possible in the cycle after RESP, so the peak rate is one transaction per 4 cycles.
- mem_req and all mem_* fields are register outputs and stay stable from REQ entry until mem_gnt.
- Reset mid-transaction aborts it. No resp is generated, and any late mem_rvalid is ignored.

## Structure
- Package mem_arb_pkg holds the state enum (ST_IDLE, ST_REQ, ST_WAIT, ST_RESP) and the owner enum (OWN_IF, OWN_DR, OWN_DW).
- The sub-module mem_port_prio_pick contains the priority decode, ready generation and starve_cnt. The top level holds the FSM and the capture registers.

## Test plan
- dw_valid, dr_valid and if_valid all high in IDLE -> dw_ready only. mem_we=1 with dw_addr=0x100, dw_wdata=0xDEADBEEF and mem_wstrb=0xF at cycle 1. dw_resp at cycle 3 with gnt/rvalid at minimum latency.
- Read at 0x200, with mem_gnt delayed 3 cycles and mem_rdata=0x12345678 arriving 2 cycles after gnt -> mem_req is held for 4 cycles with fields stable. Then dr_resp=1 and dr_rdata=0x12345678 for one cycle, and 0 in the next cycle.
- if_valid held high with dr_valid continuously high, STARVE_LIMIT=4 -> 4 reads accepted, then the 5th accept is a fetch. starve_cnt is 0 afterwards.
- Change dr_addr to 0x300 after accepting 0x200 -> mem_addr stays 0x200.
- Assert rst_n low while in WAIT, then release -> all outputs 0 and no resp. A stray mem_rvalid in IDLE produces no resp, and the next fetch completes normally.
